// File: rtl/mnist_pixel_loader.sv
// Pixel stream loader for mnist_accel: converts 8-bit pixels to fixed point and fills the frame buffer.
// Define MNIST_PIXEL_NORM_EN to mean-centre pixels (subtract 128) before the fractional shift.
module mnist_pixel_loader #(
  parameter int NPIX       = 784,
  parameter int IN_W       = 8,
  parameter int DW         = 32,
  parameter int FRAC_SHIFT = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_W-1:0]      s_data,
  input  logic                 s_last,
  output logic signed [DW-1:0] image_pixels [0:NPIX-1],
  output logic                 accel_start,
  input  logic                 accel_done,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frames_done,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NPIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  typedef enum logic [1:0] {FILL, DRAIN, FIRE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                s_ready_q, s_ready_d;
  logic                accel_start_q, accel_start_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    frames_done_q, frames_done_d;
  logic signed [DW-1:0] pix_q [0:NPIX-1];
  logic signed [DW-1:0] pix_val;
  logic                pix_we;
  logic                beat;

  assign beat = s_valid && s_ready_q;

`ifdef MNIST_PIXEL_NORM_EN
  // Flipping the offset into a 9-bit wrap gives the two's complement of (pixel - 128).
  logic [IN_W:0] centred;
  assign centred = {1'b0, s_data} - (IN_W + 1)'(2 ** (IN_W - 1));
  assign pix_val = {{(DW - IN_W - 1){centred[IN_W]}}, centred} << FRAC_SHIFT;
`else
  assign pix_val = {{(DW - IN_W){1'b0}}, s_data} << FRAC_SHIFT;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    s_ready_d     = s_ready_q;
    accel_start_d = 1'b0;
    frame_err_d   = 1'b0;
    busy_d        = busy_q;
    frames_done_d = frames_done_q;
    pix_we        = 1'b0;
    case (state_q)
      FILL: begin
        if (beat) begin
          pix_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_last) begin
              state_d       = FIRE;
              s_ready_d     = 1'b0;
              busy_d        = 1'b1;
              accel_start_d = 1'b1;
              frames_done_d = frames_done_q + CNT_W'(1);
            end else begin
              state_d     = DRAIN;
              frame_err_d = 1'b1;
            end
          end else if (s_last) begin
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (beat && s_last) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        // A done seen during FIRE is deliberately ignored; only WAIT reacts to it.
        if (accel_done) begin
          state_d   = FILL;
          idx_d     = '0;
          s_ready_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      s_ready_q     <= 1'b1;
      accel_start_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      frames_done_q <= '0;
      for (int i = 0; i < NPIX; i++) pix_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      s_ready_q     <= s_ready_d;
      accel_start_q <= accel_start_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
      frames_done_q <= frames_done_d;
      if (pix_we) pix_q[idx_q] <= pix_val;
    end
  end

  assign s_ready      = s_ready_q;
  assign accel_start  = accel_start_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;
  assign frames_done  = frames_done_q;
  assign image_pixels = pix_q;

endmodule

// File: tb/tb_mnist_pixel_loader.sv
// Scoreboard testbench for mnist_pixel_loader: frame writes are queued and compared when the accelerator start fires.
// Works in both builds; MNIST_PIXEL_NORM_EN selects the centred reference conversion.
module tb_mnist_pixel_loader;
  localparam int NPIX  = 784;
  localparam int IN_W  = 8;
  localparam int DW    = 32;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic [IN_W-1:0]      s_data;
  logic                 s_last;
  logic signed [DW-1:0] image_pixels [0:NPIX-1];
  logic                 accel_start;
  logic                 accel_done;
  logic                 frame_err;
  logic [CNT_W-1:0]     frames_done;
  logic                 busy;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } sb_t;

  sb_t sbq[$];
  int  errors = 0;
  int  checks = 0;
  int  startPulses = 0;

  mnist_pixel_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .image_pixels(image_pixels), .accel_start(accel_start),
    .accel_done(accel_done), .frame_err(frame_err), .frames_done(frames_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference pixel conversion
  function automatic logic [31:0] conv(input logic [7:0] d);
    int v;
`ifdef MNIST_PIXEL_NORM_EN
    v = int'(d) - 128;
`else
    v = int'(d);
`endif
    return 32'(v * 256);
  endfunction

  function automatic logic [7:0] patData(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'(i * 7);
      2:       return 8'(i) ^ 8'h5A;
      3:       return 8'h11;
      default: return 8'(8'h30 + i);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Start and error must never coincide; also tally start pulses
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checkOutput("start_err_excl", {31'd0, accel_start & frame_err}, 32'd0);
      if (accel_start) startPulses++;
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int k = 0; k < 20; k++) begin
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendFrame(input int first, input int lastEx, input int mode, input int lastAt, input bit push);
    logic [7:0] d;
    for (int i = first; i < lastEx; i++) begin
      d = patData(mode, i);
      if (push) sbq.push_back('{i, conv(d)});
      applyStimulus(d, i == lastAt);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic fireChecks(input int expFrames);
    sb_t e;
    checkOutput("fire_start", {31'd0, accel_start}, 32'd1);
    checkOutput("fire_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("fire_busy", {31'd0, busy}, 32'd1);
    checkOutput("fire_err", {31'd0, frame_err}, 32'd0);
    checkOutput("frames_done", {16'd0, frames_done}, 32'(expFrames));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput($sformatf("pix[%0d]", e.idx), image_pixels[e.idx], e.val);
    end
  endtask

  task automatic releaseAccel();
    accel_done = 1'b1;
    @(posedge clk); #1;
    accel_done = 1'b0;
    checkOutput("done_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nz;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; accel_done = 1'b0;
    #22 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_start", {31'd0, accel_start}, 32'd0);
    checkOutput("rst_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_frames", {16'd0, frames_done}, 32'd0);
    checkOutput("rst_pix783", image_pixels[783], 32'd0);

    // Nominal frame; a stray done during FILL must be ignored
    accel_done = 1'b1;
    sendFrame(0, 400, 0, 783, 1'b1);
    accel_done = 1'b0;
    sendFrame(400, NPIX, 0, 783, 1'b1);
    fireChecks(1);
`ifdef MNIST_PIXEL_NORM_EN
    checkOutput("norm_pix0", image_pixels[0], 32'hFFFF8000);
    checkOutput("norm_pix255", image_pixels[255], 32'h00007F00);
`else
    checkOutput("plain_pix5", image_pixels[5], 32'h00000500);
    checkOutput("plain_pix255", image_pixels[255], 32'h0000FF00);
`endif
    // Done coinciding with FIRE is ignored
    accel_done = 1'b1;
    @(posedge clk); #1;
    accel_done = 1'b0;
    checkOutput("start_single", {31'd0, accel_start}, 32'd0);
    checkOutput("wait_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("wait_hold", {31'd0, s_ready}, 32'd0);
    checkOutput("wait_busy", {31'd0, busy}, 32'd1);

    // Backpressure: valid data while waiting must not touch the buffer
    s_valid = 1'b1; s_data = 8'hAA;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("bp_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("bp_pix0", image_pixels[0], conv(8'h00));
    checkOutput("bp_pix1", image_pixels[1], conv(8'h01));
    s_valid = 1'b0;
    releaseAccel();
    applyStimulus(8'h42, 1'b0);
    checkOutput("restart_pix0", image_pixels[0], conv(8'h42));

    // Short frame: ends on beat 9
    sendFrame(1, 10, 4, 9, 1'b0);
    checkOutput("short_err", {31'd0, frame_err}, 32'd1);
    checkOutput("short_start", {31'd0, accel_start}, 32'd0);
    checkOutput("short_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("short_pix9", image_pixels[9], conv(8'h39));
    @(posedge clk); #1;
    checkOutput("short_err_pulse", {31'd0, frame_err}, 32'd0);

    // Full frame after the short one must restart at index 0
    sendFrame(0, NPIX, 1, 783, 1'b1);
    fireChecks(2);
    @(posedge clk); #1;
    releaseAccel();

    // Long frame: no last on beat 783, then three dropped beats
    sendFrame(0, NPIX, 2, -1, 1'b0);
    checkOutput("long_err", {31'd0, frame_err}, 32'd1);
    checkOutput("long_start", {31'd0, accel_start}, 32'd0);
    checkOutput("long_pix783", image_pixels[783], conv(8'(783) ^ 8'h5A));
    sendFrame(0, 3, 3, 2, 1'b0);
    checkOutput("drain_frames", {16'd0, frames_done}, 32'd2);
    checkOutput("drain_busy", {31'd0, busy}, 32'd0);
    checkOutput("drain_pix0", image_pixels[0], conv(8'h5A));
    checkOutput("drain_pix2", image_pixels[2], conv(8'h02 ^ 8'h5A));

    // Frame to reach WAIT, then asynchronous reset between edges
    sendFrame(0, NPIX, 0, 783, 1'b1);
    fireChecks(3);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    nz = 0;
    for (int i = 0; i < NPIX; i++) if (image_pixels[i] !== '0) nz++;
    checkOutput("areset_clear", 32'(nz), 32'd0);
    checkOutput("areset_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("areset_busy", {31'd0, busy}, 32'd0);
    checkOutput("areset_frames", {16'd0, frames_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    accel_done = 1'b1;
    @(posedge clk); #1;
    accel_done = 1'b0;
    checkOutput("stray_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("stray_busy", {31'd0, busy}, 32'd0);
    checkOutput("stray_start", {31'd0, accel_start}, 32'd0);
    @(posedge clk); #1;
    checkOutput("start_pulses", 32'(startPulses), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mnist_pixel_loader.md
Name: mnist_pixel_loader

Overview:
- Upstream stage of mnist_accel.
- Accepts a raw 8-bit pixel stream over a valid/ready handshake and converts each pixel to signed fixed point.
- Writes pixels into a 784-entry frame buffer that drives mnist_accel's image_pixels input directly.
- After a complete, well-formed frame: pulses start to the accelerator, blocks further input until the accelerator reports done.

Parameters:
- NPIX, 784, pixels per frame (28x28).
- IN_W, 8, raw pixel width (unsigned).
- DW, 32, output pixel width (signed, matches accelerator).
- FRAC_SHIFT, 8, left shift applied after extension (Q-format fraction bits).
- CNT_W, 16, width of frame counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  loader can accept a pixel.
- s_data  in  IN_W  raw pixel value.
- s_last  in  1  marks final pixel of a frame.
- image_pixels  out  DW x NPIX  unpacked array [0:NPIX-1], signed frame buffer to accelerator.
- accel_start  out  1  one-cycle start pulse to accelerator.
- accel_done  in  1  accelerator finished; frame buffer may be overwritten.
- frame_err  out  1  one-cycle pulse on malformed frame.
- frames_done  out  CNT_W  count of frames handed to accelerator, wraps at 2^CNT_W.
- busy  out  1  high in FIRE or WAIT.

Behaviour:
- Reset (async, immediate):
  - State FILL, index 0.
  - s_ready=1, accel_start=0, frame_err=0, busy=0, frames_done=0.
  - All image_pixels entries cleared to 0.
  - Reset mid-frame or mid-WAIT discards all progress; the accelerator is not notified.
- A beat transfers when s_valid && s_ready at a rising edge.
- Conversion (macro off): value = zero_extend(s_data to DW) << FRAC_SHIFT; written to image_pixels[index].
- A write accepted at edge t is visible on image_pixels after t.
- States:
  - FILL:
    - s_ready=1.
    - Beat with index<NPIX-1 and s_last=0: write, index++.
    - Beat with index<NPIX-1 and s_last=1 (short frame): write, frame_err pulse next cycle, index->0, stay FILL.
    - Beat with index==NPIX-1 and s_last=1: write, go to FIRE.
    - Beat with index==NPIX-1 and s_last=0 (long frame): write, frame_err pulse, index->0, go to DRAIN.
  - DRAIN:
    - s_ready=1; beats are discarded, no writes.
    - Beat with s_last=1 -> FILL, index 0.
  - FIRE:
    - Exactly one cycle; accel_start=1, s_ready=0, busy=1, frames_done++.
    - Always -> WAIT.
  - WAIT:
    - s_ready=0, busy=1; buffer frozen.
    - accel_done=1 -> FILL, index 0; s_ready=1 on the following cycle.
- Latency: last beat accepted at edge t -> accel_start high for cycle t..t+1 only. s_ready is low from t onward until the cycle after accel_done is sampled in WAIT.
- accel_done sampled in FILL, DRAIN or FIRE is ignored; it is not latched.
- accel_done arriving in the same cycle as FIRE is ignored; WAIT requires a later accel_done.
- frame_err and accel_start are never high in the same cycle.
- frames_done wraps 0xFFFF -> 0x0000.
- s_data is don't-care when s_valid=0; no write occurs.

Optional Feature:
- Macro: MNIST_PIXEL_NORM_EN.
- Defined: pixel is mean-centred before shifting: value = (signed(s_data) - 128, sign-extended to DW) << FRAC_SHIFT. Result range is -128<<FRAC_SHIFT .. 127<<FRAC_SHIFT; 0x00 maps to 0xFFFF8000 and 0xFF maps to 0x00007F00 with defaults.
- Undefined: plain zero-extension as in Behaviour; 0x00 -> 0x00000000, 0xFF -> 0x0000FF00.
- Handshake and FSM are identical in both builds.

Test Plan:
- Nominal frame:
  - Stimulus: 784 beats, s_data=index[7:0], s_last on beat 783, s_valid held high.
  - Response: image_pixels[5]=0x00000500, [783]=0x0000_0F00; accel_start single pulse the cycle after beat 783; frames_done=1; s_ready=0 until accel_done.
- Backpressure/hold:
  - Stimulus: in WAIT, drive s_valid=1, s_data=0xAA for 50 cycles, then pulse accel_done.
  - Response: no buffer change; s_ready returns 1 the cycle after accel_done; next beat lands in index 0.
- Short frame:
  - Stimulus: s_last on beat 9.
  - Response: frame_err pulse; no accel_start; a following full 784-beat frame starts at index 0 and fires normally.
- Long frame:
  - Stimulus: 784 beats without s_last, then 3 extra beats, last with s_last.
  - Response: frame_err after beat 783; extra beats dropped; frames_done unchanged.
- Reset mid-WAIT:
  - Stimulus: assert reset asynchronously between clock edges while in WAIT.
  - Response: s_ready=1, busy=0, frames_done=0, image_pixels all zero immediately; subsequent stray accel_done ignored.
- Normalisation build:
  - Stimulus: with MNIST_PIXEL_NORM_EN defined, frame with pixel 0=0x00, pixel 1=0xFF.
  - Response: image_pixels[0]=0xFFFF8000, [1]=0x00007F00.
